// File: rtl/multi_clock_divider_pkg.sv
// Shared types, reset defaults and config validation for the multi-channel clock divider.
package multi_clock_divider_pkg;

  localparam int DIV_W_DEFAULT = 8;
  localparam int DEFAULT_DIV   = 4;
  localparam int DEFAULT_HIGH  = 2;

  typedef logic [DIV_W_DEFAULT-1:0] div_count_t;

  typedef struct packed {
    div_count_t div;
    div_count_t high;
  } div_config_t;

  // A config is usable when the channel exists, the period is at least two
  // cycles, and both the high and the low phase are at least one cycle long.
  function automatic logic cfg_valid(input int unsigned ch, input int unsigned div,
                                     input int unsigned high, input int unsigned num_ch);
    return (ch < num_ch) && (div >= 2) && (high >= 1) && (high < div);
  endfunction

endpackage

// File: rtl/multi_clock_divider_channel.sv
// One divider channel: period counter, active and pending config, registered level and tick.
module multi_clock_divider_channel
  import multi_clock_divider_pkg::*;
#(
  parameter int DIV_W    = DIV_W_DEFAULT,
  parameter int RST_DIV  = DEFAULT_DIV,
  parameter int RST_HIGH = DEFAULT_HIGH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] wr_div_i,
  input  logic [DIV_W-1:0] wr_high_i,
  output logic             pending_o,
  output logic             clk_o,
  output logic             tick_o
);

  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] high;
  } cfg_t;

  cfg_t             act_q, act_d;
  cfg_t             pend_q, pend_d;
  logic             pending_q, pending_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             wrap;
  logic             restart;

  always_comb begin
    wrap      = (cnt_q == act_q.div - DIV_W'(1));
    // A disabled channel sits at a period boundary, so it may take new config at once.
    restart   = !en_i || sync_i || wrap;
    act_d     = act_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    if (restart && pending_q) begin
      act_d     = pend_q;
      pending_d = 1'b0;
    end
    // A write landing on the boundary cycle stays pending for the next one.
    if (wr_i) begin
      pend_d.div  = wr_div_i;
      pend_d.high = wr_high_i;
      pending_d   = 1'b1;
    end
    if (en_i) begin
      clk_d  = (cnt_q < act_q.high);
      tick_d = (cnt_q == '0);
      cnt_d  = (sync_i || wrap) ? '0 : cnt_q + DIV_W'(1);
    end else begin
      clk_d  = 1'b0;
      tick_d = 1'b0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      act_q.div  <= DIV_W'(RST_DIV);
      act_q.high <= DIV_W'(RST_HIGH);
      pend_q     <= '0;
      pending_q  <= 1'b0;
      cnt_q      <= '0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      act_q      <= act_d;
      pend_q     <= pend_d;
      pending_q  <= pending_d;
      cnt_q      <= cnt_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
    end
  end

  assign pending_o = pending_q;
  assign clk_o     = clk_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/multi_clock_divider.sv
// N-channel programmable clock divider: config write decode/validation, error flag, sync fan-out.
module multi_clock_divider
  import multi_clock_divider_pkg::*;
#(
  parameter  int NUM_CH       = 4,
  parameter  int DIV_W        = DIV_W_DEFAULT,
  parameter  int DEFAULT_DIV  = multi_clock_divider_pkg::DEFAULT_DIV,
  parameter  int DEFAULT_HIGH = multi_clock_divider_pkg::DEFAULT_HIGH,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              syncReq_i,
  input  logic              cfgWe_i,
  input  logic [CH_W-1:0]   cfgCh_i,
  input  logic [DIV_W-1:0]  cfgDiv_i,
  input  logic [DIV_W-1:0]  cfgHigh_i,
  output logic              cfgErr_o,
  output logic [NUM_CH-1:0] cfgPending_o,
  output logic [NUM_CH-1:0] clkOut_o,
  output logic [NUM_CH-1:0] tick_o
);

  logic              accept;
  logic              cfg_err_q, cfg_err_d;
  logic [NUM_CH-1:0] wr_sel;

  assign accept    = cfgWe_i && cfg_valid(32'(cfgCh_i), 32'(cfgDiv_i), 32'(cfgHigh_i), NUM_CH);
  assign cfg_err_d = cfgWe_i && !accept;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfgErr_o = cfg_err_q;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign wr_sel[gi] = accept && (cfgCh_i == CH_W'(gi));

    multi_clock_divider_channel #(
      .DIV_W    (DIV_W),
      .RST_DIV  (DEFAULT_DIV),
      .RST_HIGH (DEFAULT_HIGH)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .en_i      (en_i[gi]),
      .sync_i    (syncReq_i),
      .wr_i      (wr_sel[gi]),
      .wr_div_i  (cfgDiv_i),
      .wr_high_i (cfgHigh_i),
      .pending_o (cfgPending_o[gi]),
      .clk_o     (clkOut_o[gi]),
      .tick_o    (tick_o[gi])
    );
  end

endmodule
